// File: rtl/mont_mult_iter_pkg.sv
// mont_mult_iter_pkg: shared constants, sizing helpers and FSM states for mont_mult_iter
package mont_mult_iter_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;
  localparam logic [254:0] BLS12_381_R =
    255'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;
  // M = 1 mod 2^32, so -M^-1 is all ones for both 16- and 32-bit digits
  localparam logic [15:0] BLS12_381_NINV16 = 16'hFFFF;
  localparam logic [31:0] BLS12_381_NINV32 = 32'hFFFF_FFFF;
  function automatic int num_digits(input int dw, input int gw);
    return (dw + gw - 1) / gw;
  endfunction
  function automatic int acc_width(input int dw, input int gw);
    return dw + gw + 2;
  endfunction
endpackage

// File: rtl/mont_mult_iter_digit_step.sv
// mont_mult_iter_digit_step: one radix-2^DIGIT_WIDTH Montgomery iteration, t_o = (t_i + a_i*b_i + q*m_i) >> DIGIT_WIDTH
// Ports: t_i accumulator in, a_i current op1 digit, b_i multiplier, m_i modulus, t_o accumulator out
module mont_mult_iter_digit_step #(
  parameter int DATA_WIDTH = 255,
  parameter int DIGIT_WIDTH = 16,
  parameter logic [DIGIT_WIDTH-1:0] NINV = '1,
  parameter int TW = DATA_WIDTH + DIGIT_WIDTH + 2
) (
  input  logic [TW-1:0]          t_i,
  input  logic [DIGIT_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0]  b_i,
  input  logic [DATA_WIDTH-1:0]  m_i,
  output logic [TW-1:0]          t_o
);
  localparam int SW = TW + DIGIT_WIDTH;
  logic [SW-1:0] s0, s1;
  logic [DIGIT_WIDTH-1:0] m_fac;
  assign s0 = SW'(t_i) + SW'(a_i) * SW'(b_i);
  // factor chosen so the low digit of s1 is zero and the shift is exact
  assign m_fac = DIGIT_WIDTH'(s0[DIGIT_WIDTH-1:0] * NINV);
  assign s1 = s0 + SW'(m_fac) * SW'(m_i);
  assign t_o = TW'(s1 >> DIGIT_WIDTH);
endmodule

// File: rtl/mont_mult_iter.sv
// mont_mult_iter: word-serial Montgomery multiplier, res = op1*op2*R^-1 mod MODULUS
// Ports: op_valid_i/op_ready_o request handshake with op1_i, op2_i, op_mode_i (1 = from-Montgomery) and op_tag_i;
//        res_valid_o/res_ready_i result handshake with res_o and the echoed res_tag_o
module mont_mult_iter
  import mont_mult_iter_pkg::*;
#(
  parameter int DATA_WIDTH = 255,
  parameter logic [DATA_WIDTH-1:0] MODULUS = DATA_WIDTH'(BLS12_381_R),
  parameter int DIGIT_WIDTH = 16,
  parameter logic [DIGIT_WIDTH-1:0] MODULUS_NINV =
    DIGIT_WIDTH'(DIGIT_WIDTH == 32 ? BLS12_381_NINV32 : 32'(BLS12_381_NINV16)),
  parameter int TAG_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid_i,
  output logic                  op_ready_o,
  input  logic                  op_mode_i,
  input  logic [DATA_WIDTH-1:0] op1_i,
  input  logic [DATA_WIDTH-1:0] op2_i,
  input  logic [TAG_WIDTH-1:0]  op_tag_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic [TAG_WIDTH-1:0]  res_tag_o
);
  localparam int ND = num_digits(DATA_WIDTH, DIGIT_WIDTH);
  localparam int TW = acc_width(DATA_WIDTH, DIGIT_WIDTH);
  localparam int OPW = ND * DIGIT_WIDTH;
  localparam int CW = ND > 1 ? $clog2(ND) : 1;
  state_e state_q, state_d;
  logic [OPW-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q, res_q, res_d;
  logic [TW-1:0] t_q, t_d;
  logic [CW-1:0] cnt_q;
  logic [TAG_WIDTH-1:0] tag_q, res_tag_q;
  logic accept, last;
  mont_mult_iter_digit_step #(
    .DATA_WIDTH(DATA_WIDTH), .DIGIT_WIDTH(DIGIT_WIDTH), .NINV(MODULUS_NINV), .TW(TW)
  ) u_step (
    .t_i(t_q), .a_i(a_q[DIGIT_WIDTH-1:0]), .b_i(b_q), .m_i(MODULUS), .t_o(t_d)
  );
  assign op_ready_o = state_q == IDLE || (state_q == DONE && res_ready_i);
  assign accept = op_valid_i && op_ready_o;
  assign last = cnt_q == CW'(ND - 1);
  assign res_valid_o = state_q == DONE;
  assign res_o = res_q;
  assign res_tag_o = res_tag_q;
  always_comb begin
    state_d = accept ? RUN
            : state_q == RUN ? (last ? FIX : RUN)
            : state_q == FIX ? DONE
            : state_q == DONE && res_ready_i ? IDLE
            : state_q;
    res_d = t_q >= TW'(MODULUS) ? DATA_WIDTH'(t_q - TW'(MODULUS)) : DATA_WIDTH'(t_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      t_q <= '0;
      cnt_q <= '0;
      tag_q <= '0;
      res_q <= '0;
      res_tag_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q <= OPW'(op1_i);
        b_q <= op_mode_i ? DATA_WIDTH'(1) : op2_i;
        tag_q <= op_tag_i;
        t_q <= '0;
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        a_q <= a_q >> DIGIT_WIDTH;
        t_q <= t_d;
        cnt_q <= cnt_q + CW'(1);
      end
      if (state_q == FIX) begin
        res_q <= res_d;
        res_tag_q <= tag_q;
      end
    end
  end
endmodule

// File: tb/tb_mont_mult_iter.sv
// tb_mont_mult_iter: self-checking bench for mont_mult_iter against a bit-serial modular model
module tb_mont_mult_iter;
  localparam int DW = 255;
  localparam int RB = 256;
  localparam int NRAND = 200;
  localparam logic [254:0] M =
    255'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;
  typedef struct packed {
    logic [254:0] r;
    logic [7:0]   t;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  logic op_valid_i = 0;
  logic op_ready_o;
  logic op_mode_i = 0;
  logic [DW-1:0] op1_i = '0;
  logic [DW-1:0] op2_i = '0;
  logic [7:0] op_tag_i = '0;
  logic res_valid_o;
  logic res_ready_i = 1;
  logic [DW-1:0] res_o;
  logic [7:0] res_tag_o;
  int passed = 0;
  int total = 0;
  exp_t sb[$];
  mont_mult_iter dut (
    .clk(clk), .rst(rst),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_mode_i(op_mode_i),
    .op1_i(op1_i), .op2_i(op2_i), .op_tag_i(op_tag_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_o(res_o), .res_tag_o(res_tag_o)
  );
  always #5 clk = ~clk;
  function automatic logic [254:0] mulpow2(input logic [254:0] x, input int n);
    logic [255:0] y;
    y = {1'b0, x};
    for (int i = 0; i < n; i++) begin
      y = y << 1;
      if (y >= {1'b0, M}) y = y - {1'b0, M};
    end
    return y[254:0];
  endfunction
  function automatic logic [254:0] mont(input logic [254:0] a, input logic [254:0] b);
    logic [509:0] p;
    logic [255:0] x;
    p = 510'(a) * 510'(b);
    p = p % 510'(M);
    x = 256'(p);
    for (int i = 0; i < RB; i++) x = x[0] ? (x + 256'(M)) >> 1 : x >> 1;
    return x[254:0];
  endfunction
  function automatic logic [254:0] rand_fe();
    logic [255:0] x;
    x = '0;
    for (int i = 0; i < 8; i++) x = {x[223:0], 32'($urandom())};
    return 255'(x % {1'b0, M});
  endfunction
  task automatic run_op(input logic [254:0] a, input logic [254:0] b, input logic md,
                        input logic [7:0] tg, output logic [254:0] r, output logic [7:0] rt,
                        output int lat);
    bit ok;
    @(posedge clk); #1;
    res_ready_i = 1; op_valid_i = 1; op1_i = a; op2_i = b; op_mode_i = md; op_tag_i = tg;
    @(posedge clk); #1;
    op_valid_i = 0; op1_i = rand_fe(); op2_i = rand_fe(); op_mode_i = ~md; op_tag_i = ~tg;
    ok = 0;
    lat = -1;
    for (int k = 1; k <= 60 && !ok; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (res_valid_o) begin ok = 1; lat = k; end
    end
    r = res_o;
    rt = res_tag_o;
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    total++; if (op_ready_o !== 1'b1) $display("FAIL reset_ready got %0b want 1", op_ready_o); else passed++;
    total++; if (res_valid_o !== 1'b0) $display("FAIL reset_valid got %0b want 0", res_valid_o); else passed++;
    total++; if (res_o !== '0) $display("FAIL reset_res got %h want 0", res_o); else passed++;
    total++; if (res_tag_o !== 8'h00) $display("FAIL reset_tag got %h want 00", res_tag_o); else passed++;
  endtask
  task automatic test_zero();
    logic [254:0] r; logic [7:0] rt; int lat;
    run_op('0, 255'd12345, 0, 8'h3C, r, rt, lat);
    total++; if (r !== '0) $display("FAIL zero_res got %h want 0", r); else passed++;
    total++; if (rt !== 8'h3C) $display("FAIL zero_tag got %h want 3c", rt); else passed++;
    total++; if (lat !== 17) $display("FAIL zero_latency got %0d want 17", lat); else passed++;
  endtask
  task automatic test_fix_path();
    logic [254:0] r, rinv; logic [7:0] rt; int lat;
    rinv = mont(255'd1, 255'd1);
    run_op(255'd1, 255'd1, 0, 8'h01, r, rt, lat);
    total++; if (r !== rinv) $display("FAIL fix_one got %h want %h", r, rinv); else passed++;
    run_op(M - 255'd1, M - 255'd1, 0, 8'h02, r, rt, lat);
    total++; if (r !== rinv) $display("FAIL fix_mmax got %h want %h", r, rinv); else passed++;
    total++; if (rt !== 8'h02) $display("FAIL fix_tag got %h want 02", rt); else passed++;
  endtask
  task automatic test_roundtrip();
    logic [254:0] r, e; logic [7:0] rt; int lat;
    e = mulpow2(255'd5, RB);
    run_op(mulpow2(255'd1, 2 * RB), 255'd5, 0, 8'h31, r, rt, lat);
    total++; if (r !== e) $display("FAIL to_mont got %h want %h", r, e); else passed++;
    run_op(r, rand_fe(), 1, 8'h32, r, rt, lat);
    total++; if (r !== 255'd5) $display("FAIL from_mont got %h want 5", r); else passed++;
    total++; if (rt !== 8'h32) $display("FAIL from_mont_tag got %h want 32", rt); else passed++;
  endtask
  task automatic test_backpressure();
    logic [254:0] a1, b1, a2, b2, e1, e2; bit seen; int lat;
    a1 = rand_fe(); b1 = rand_fe(); a2 = rand_fe(); b2 = rand_fe();
    e1 = mont(a1, b1); e2 = mont(a2, b2);
    @(posedge clk); #1;
    res_ready_i = 0; op_valid_i = 1; op1_i = a1; op2_i = b1; op_mode_i = 0; op_tag_i = 8'h11;
    @(posedge clk); #1;
    op1_i = a2; op2_i = b2; op_tag_i = 8'h22;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin @(negedge clk); seen = res_valid_o; end
    total++; if (!seen) $display("FAIL bp_result_timeout got 0 want 1"); else passed++;
    for (int k = 0; k < 10; k++) begin
      total++; if (res_valid_o !== 1'b1) $display("FAIL bp_valid cyc %0d got %0b want 1", k, res_valid_o); else passed++;
      total++; if (res_o !== e1) $display("FAIL bp_res cyc %0d got %h want %h", k, res_o, e1); else passed++;
      total++; if (res_tag_o !== 8'h11) $display("FAIL bp_tag cyc %0d got %h want 11", k, res_tag_o); else passed++;
      total++; if (op_ready_o !== 1'b0) $display("FAIL bp_ready cyc %0d got %0b want 0", k, op_ready_o); else passed++;
      @(negedge clk);
    end
    res_ready_i = 1;
    #1;
    total++; if (op_ready_o !== 1'b1) $display("FAIL bp_release_ready got %0b want 1", op_ready_o); else passed++;
    @(posedge clk);
    @(negedge clk);
    op_valid_i = 0;
    total++; if (res_valid_o !== 1'b0) $display("FAIL bp_consumed got %0b want 0", res_valid_o); else passed++;
    total++; if (op_ready_o !== 1'b0) $display("FAIL bp_new_running got %0b want 0", op_ready_o); else passed++;
    lat = -1;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (res_valid_o) lat = k;
    end
    total++; if (lat !== 17) $display("FAIL bp_second_latency got %0d want 17", lat); else passed++;
    total++; if (res_o !== e2) $display("FAIL bp_second_res got %h want %h", res_o, e2); else passed++;
    total++; if (res_tag_o !== 8'h22) $display("FAIL bp_second_tag got %h want 22", res_tag_o); else passed++;
    @(posedge clk); #1;
  endtask
  task automatic test_reset_mid();
    logic [254:0] a, b, r; logic [7:0] rt; int lat; bit seen;
    @(posedge clk); #1;
    res_ready_i = 1; op_valid_i = 1; op1_i = rand_fe(); op2_i = rand_fe(); op_mode_i = 0; op_tag_i = 8'h77;
    @(posedge clk); #1;
    op_valid_i = 0;
    repeat (7) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    total++; if (res_valid_o !== 1'b0) $display("FAIL rstmid_valid got %0b want 0", res_valid_o); else passed++;
    total++; if (op_ready_o !== 1'b1) $display("FAIL rstmid_idle got %0b want 1", op_ready_o); else passed++;
    seen = 0;
    repeat (25) begin @(negedge clk); if (res_valid_o) seen = 1; end
    total++; if (seen) $display("FAIL rstmid_abandoned got 1 want 0"); else passed++;
    a = rand_fe(); b = rand_fe();
    run_op(a, b, 0, 8'hA5, r, rt, lat);
    total++; if (r !== mont(a, b)) $display("FAIL rstmid_next_res got %h want %h", r, mont(a, b)); else passed++;
    total++; if (rt !== 8'hA5) $display("FAIL rstmid_next_tag got %h want a5", rt); else passed++;
  endtask
  task automatic test_random();
    logic [254:0] a, b; logic md; logic [7:0] tg; exp_t e; bit pend; int sent, rcv;
    a = '0; b = '0; md = 0; tg = '0; pend = 0; sent = 0; rcv = 0;
    for (int cyc = 0; cyc < 20000 && rcv < NRAND; cyc++) begin
      @(posedge clk); #1;
      if (!pend && sent < NRAND && $urandom_range(0, 1) == 1) begin
        a = rand_fe(); b = rand_fe(); md = $urandom_range(0, 3) == 0; tg = 8'($urandom());
        op_valid_i = 1; op1_i = a; op2_i = b; op_mode_i = md; op_tag_i = tg;
        pend = 1;
      end else if (!pend) op_valid_i = 0;
      res_ready_i = $urandom_range(0, 3) != 0;
      @(negedge clk);
      if (op_valid_i && op_ready_o) begin
        e.r = mont(a, md ? 255'd1 : b);
        e.t = tg;
        sb.push_back(e);
        sent++;
        pend = 0;
      end
      if (res_valid_o && res_ready_i) begin
        rcv++;
        if (sb.size() == 0) begin
          total++; $display("FAIL rand_unexpected got result %h want none", res_o);
        end else begin
          e = sb.pop_front();
          total++; if (res_o !== e.r) $display("FAIL rand_res #%0d got %h want %h", rcv, res_o, e.r); else passed++;
          total++; if (res_tag_o !== e.t) $display("FAIL rand_tag #%0d got %h want %h", rcv, res_tag_o, e.t); else passed++;
        end
      end
    end
    @(posedge clk); #1;
    op_valid_i = 0; res_ready_i = 1;
    total++; if (rcv !== NRAND || sb.size() != 0) $display("FAIL rand_drain got %0d results want %0d", rcv, NRAND); else passed++;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_zero();
    test_fix_path();
    test_roundtrip();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
